// File: rtl/tta_pkg.sv
// Shared types and constants for the TTA functional-unit scheduler.
package tta_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;

    typedef enum logic [1:0] {
        FU_ADD  = 2'd0,
        FU_SUB  = 2'd1,
        FU_LSU  = 2'd2,
        FU_NONE = 2'd3
    } fu_id_e;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

endpackage

// File: rtl/tta_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer; the pointer moves
// past the winner only when the caller confirms the grant with upd_i.
module tta_rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic          hit;

    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int k = 0; k < N; k++) begin
            if (!hit && req_i[(int'(ptr_q) + k) % N]) begin
                hit = 1'b1;
                win = PW'((int'(ptr_q) + k) % N);
            end
        end
    end

    always_comb begin
        gnt_o      = '0;
        gnt_o[win] = hit;
    end

    assign idx_o = win;
    assign any_o = hit;

    // Kept apart from the search so the upd_i path (which depends on any_o) has no loop.
    assign ptr_d = !upd_i ? ptr_q : (int'(win) == N - 1) ? '0 : win + PW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/tta_fu_scheduler.sv
// Issue-side scheduler: per-FU round-robin, transport-bus cap, LSU occupancy and load scoreboard.
// Define TTA_SCHED_PERF_EN to add the stall / bus-denial performance counters.
//
//   state    | meaning
//   LSU_IDLE | LSU free, no access in flight
//   LSU_BUSY | access in flight, cnt = remaining busy cycles; accepts a new grant at cnt==1
module tta_fu_scheduler
    import tta_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int NUM_FU  = 3,
    parameter  int BUS_CNT = 2,
    parameter  int LSU_LAT = 2,
    localparam int SW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N-1:0]           req_valid_i,
    input  logic [2*N-1:0]         req_fu_i,
    input  logic [N-1:0]           req_load_i,
    input  logic [REG_W*N-1:0]     req_rs1_i,
    input  logic [REG_W*N-1:0]     req_rs2_i,
    input  logic [REG_W*N-1:0]     req_rd_i,
    output logic [N-1:0]           req_ready_o,
    output logic [NUM_FU-1:0]      grant_valid_o,
    output logic [NUM_FU*SW-1:0]   grant_slot_o,
    output logic                   wb_valid_o,
    output logic [REG_W-1:0]       wb_rd_o
`ifdef TTA_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_stall_cnt_o,
    output logic [31:0]            perf_bus_deny_cnt_o
`endif
);

    localparam int FW      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CW      = $clog2(LSU_LAT + 1);
    localparam int LSU_IDX = int'(FU_LSU);

    logic [NUM_FU-1:0][N-1:0]  elig;
    logic [NUM_FU-1:0][N-1:0]  arb_gnt;
    logic [NUM_FU-1:0][SW-1:0] arb_idx;
    logic [NUM_FU-1:0]         has_win;
    logic [NUM_FU-1:0]         fu_gnt;
    logic                      bus_deny;
    logic                      lsu_free;
    logic [SW-1:0]             lsu_slot;
    int                        used;
    int                        fsel;

    logic [FW-1:0]         fu_ptr_q, fu_ptr_d;
    lsu_state_e            lsu_state_q, lsu_state_d;
    logic [CW-1:0]         lsu_cnt_q, lsu_cnt_d;
    logic                  lsu_load_q, lsu_load_d;
    logic [REG_W-1:0]      lsu_rd_q, lsu_rd_d;
    logic [NUM_REGS-1:0]   sb_q, sb_d;
    logic [NUM_FU-1:0]     grant_valid_q;
    logic [NUM_FU*SW-1:0]  grant_slot_q, grant_slot_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]      wb_rd_q, wb_rd_d;

    assign lsu_free = (lsu_state_q == LSU_IDLE) || (lsu_cnt_q == CW'(1));

    // x0 is never set in the scoreboard, so it can be looked up like any other register.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            for (int f = 0; f < NUM_FU; f++) begin
                elig[f][i] = req_valid_i[i]
                          && (req_fu_i[2*i +: 2] == 2'(f))
                          && ((f != LSU_IDX) || lsu_free)
                          && !sb_q[req_rs1_i[REG_W*i +: REG_W]]
                          && !sb_q[req_rs2_i[REG_W*i +: REG_W]]
                          && !sb_q[req_rd_i[REG_W*i +: REG_W]];
            end
        end
    end

    for (genvar f = 0; f < NUM_FU; f++) begin : g_arb
        tta_rr_arbiter #(.N(N)) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .req_i (elig[f]),
            .upd_i (fu_gnt[f]),
            .gnt_o (arb_gnt[f]),
            .idx_o (arb_idx[f]),
            .any_o (has_win[f])
        );
    end

    always_comb begin
        fu_gnt   = '0;
        bus_deny = 1'b0;
        used     = 0;
        fsel     = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            fsel = (int'(fu_ptr_q) + k) % NUM_FU;
            if (has_win[fsel]) begin
                if (used < BUS_CNT) begin
                    fu_gnt[fsel] = 1'b1;
                    used         = used + 1;
                end else begin
                    bus_deny = 1'b1;
                end
            end
        end
    end

    assign fu_ptr_d = !bus_deny ? fu_ptr_q
                    : (fu_ptr_q == FW'(NUM_FU - 1)) ? '0 : fu_ptr_q + FW'(1);

    always_comb begin
        req_ready_o  = '0;
        grant_slot_d = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (fu_gnt[f]) begin
                req_ready_o                = req_ready_o | arb_gnt[f];
                grant_slot_d[SW*f +: SW]   = arb_idx[f];
            end
        end
    end

    assign lsu_slot = arb_idx[LSU_IDX];

    always_comb begin
        lsu_state_d = lsu_state_q;
        lsu_cnt_d   = lsu_cnt_q;
        lsu_load_d  = lsu_load_q;
        lsu_rd_d    = lsu_rd_q;
        wb_valid_d  = (lsu_state_q == LSU_BUSY) && (lsu_cnt_q == CW'(1)) && lsu_load_q;
        wb_rd_d     = wb_valid_d ? lsu_rd_q : '0;
        if (lsu_state_q == LSU_BUSY) begin
            lsu_cnt_d = lsu_cnt_q - CW'(1);
            if (lsu_cnt_q == CW'(1)) lsu_state_d = LSU_IDLE;
        end
        if (fu_gnt[LSU_IDX]) begin
            lsu_state_d = LSU_BUSY;
            lsu_cnt_d   = CW'(LSU_LAT);
            lsu_load_d  = req_load_i[lsu_slot];
            lsu_rd_d    = req_rd_i[REG_W*int'(lsu_slot) +: REG_W];
        end
    end

    // Set after clear so a same-cycle set of the retiring register wins.
    always_comb begin
        sb_d = sb_q;
        if (wb_valid_q) sb_d[wb_rd_q] = 1'b0;
        if (fu_gnt[LSU_IDX] && lsu_load_d && (lsu_rd_d != '0)) sb_d[lsu_rd_d] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fu_ptr_q      <= '0;
            lsu_state_q   <= LSU_IDLE;
            lsu_cnt_q     <= '0;
            lsu_load_q    <= 1'b0;
            lsu_rd_q      <= '0;
            sb_q          <= '0;
            grant_valid_q <= '0;
            grant_slot_q  <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
        end else begin
            fu_ptr_q      <= fu_ptr_d;
            lsu_state_q   <= lsu_state_d;
            lsu_cnt_q     <= lsu_cnt_d;
            lsu_load_q    <= lsu_load_d;
            lsu_rd_q      <= lsu_rd_d;
            sb_q          <= sb_d;
            grant_valid_q <= fu_gnt;
            grant_slot_q  <= grant_slot_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
        end
    end

    assign grant_valid_o = grant_valid_q;
    assign grant_slot_o  = grant_slot_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_rd_o       = wb_rd_q;

`ifdef TTA_SCHED_PERF_EN
    logic [31:0] perf_stall_q, perf_deny_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_deny_q  <= '0;
        end else begin
            if (|(req_valid_i & ~req_ready_o) && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 32'd1;
            if (bus_deny && (perf_deny_q != '1))                      perf_deny_q  <= perf_deny_q + 32'd1;
        end
    end

    assign perf_stall_cnt_o    = perf_stall_q;
    assign perf_bus_deny_cnt_o = perf_deny_q;
`endif

endmodule

// File: tb/tb_tta_fu_scheduler.sv
// Directed bench for tta_fu_scheduler (3 slots so the 2-bus cap can actually deny).
module tb_tta_fu_scheduler;

    localparam int N  = 3;
    localparam int SW = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [5:0]  req_fu;
    logic [2:0]  req_load;
    logic [14:0] req_rs1, req_rs2, req_rd;
    logic [2:0]  req_ready;
    logic [2:0]  grant_valid;
    logic [5:0]  grant_slot;
    logic        wb_valid;
    logic [4:0]  wb_rd;
`ifdef TTA_SCHED_PERF_EN
    logic [31:0] perf_stall_cnt, perf_bus_deny_cnt;
`endif

    tta_fu_scheduler #(.N(N), .NUM_FU(3), .BUS_CNT(2), .LSU_LAT(2)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_fu_i      (req_fu),
        .req_load_i    (req_load),
        .req_rs1_i     (req_rs1),
        .req_rs2_i     (req_rs2),
        .req_rd_i      (req_rd),
        .req_ready_o   (req_ready),
        .grant_valid_o (grant_valid),
        .grant_slot_o  (grant_slot),
        .wb_valid_o    (wb_valid),
        .wb_rd_o       (wb_rd)
`ifdef TTA_SCHED_PERF_EN
        ,
        .perf_stall_cnt_o    (perf_stall_cnt),
        .perf_bus_deny_cnt_o (perf_bus_deny_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic [5:0]  fu;
        logic [2:0]  ld;
        logic [14:0] rs1, rs2, rd;
        logic [2:0]  e_rdy;
        logic [2:0]  e_gv;
        logic [5:0]  e_gs;
        logic        e_wb;
        logic [4:0]  e_wbrd;
    } vec_t;

    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    localparam logic [14:0] Z = 15'd0;

    function automatic logic [14:0] t3(input int a2, input int a1, input int a0);
        return {5'(a2), 5'(a1), 5'(a0)};
    endfunction

    function automatic logic [5:0] f3(input int a2, input int a1, input int a0);
        return {2'(a2), 2'(a1), 2'(a0)};
    endfunction

    task automatic add(input logic [2:0] v, input logic [5:0] fu, input logic [2:0] ld,
                       input logic [14:0] rs1, input logic [14:0] rs2, input logic [14:0] rd,
                       input logic [2:0] rdy, input logic [2:0] gv, input logic [5:0] gs,
                       input logic wb, input logic [4:0] wbrd);
        vec_t e;
        e.v = v; e.fu = fu; e.ld = ld; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.e_rdy = rdy; e.e_gv = gv; e.e_gs = gs; e.e_wb = wb; e.e_wbrd = wbrd;
        tv.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [5:0] fu, input logic [2:0] ld,
                         input logic [14:0] rs1, input logic [14:0] rs2, input logic [14:0] rd);
        req_valid = v; req_fu = fu; req_load = ld;
        req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    endtask

    task automatic idle();
        drive(3'b000, 6'd0, 3'b000, Z, Z, Z);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // contention on ADD between slots 0 and 1
        add(3'b000, f3(0,0,0), 3'b000, Z, Z, Z,            3'b000, 3'b000, f3(0,0,0), 0, 0);
        add(3'b011, f3(0,0,0), 3'b000, Z, Z, t3(0,2,1),    3'b001, 3'b000, f3(0,0,0), 0, 0);
        add(3'b011, f3(0,0,0), 3'b000, Z, Z, t3(0,2,1),    3'b010, 3'b001, f3(0,0,0), 0, 0);
        add(3'b011, f3(0,0,0), 3'b000, Z, Z, t3(0,2,1),    3'b001, 3'b001, f3(0,0,1), 0, 0);
        add(3'b011, f3(0,0,0), 3'b000, Z, Z, t3(0,2,1),    3'b010, 3'b001, f3(0,0,0), 0, 0);
        // bus cap: two FUs, then three
        add(3'b011, f3(0,2,0), 3'b000, Z, Z, Z,            3'b011, 3'b001, f3(0,0,1), 0, 0);
        add(3'b000, f3(0,0,0), 3'b000, Z, Z, Z,            3'b000, 3'b101, f3(1,0,0), 0, 0);
        add(3'b111, f3(2,1,0), 3'b000, Z, Z, Z,            3'b011, 3'b000, f3(0,0,0), 0, 0);
        add(3'b111, f3(2,1,0), 3'b000, Z, Z, Z,            3'b110, 3'b011, f3(0,1,0), 0, 0);
        add(3'b001, f3(0,0,0), 3'b000, Z, Z, Z,            3'b001, 3'b110, f3(2,1,0), 0, 0);
        add(3'b000, f3(0,0,0), 3'b000, Z, Z, Z,            3'b000, 3'b001, f3(0,0,0), 0, 0);
        // LSU occupancy and load write-back
        add(3'b001, f3(0,0,2), 3'b001, Z, Z, t3(0,0,5),    3'b001, 3'b000, f3(0,0,0), 0, 0);
        add(3'b010, f3(0,2,0), 3'b010, Z, Z, t3(0,6,0),    3'b000, 3'b100, f3(0,0,0), 0, 0);
        add(3'b010, f3(0,2,0), 3'b010, Z, Z, t3(0,6,0),    3'b010, 3'b000, f3(0,0,0), 0, 0);
        add(3'b000, f3(0,0,0), 3'b000, Z, Z, Z,            3'b000, 3'b100, f3(1,0,0), 1, 5);
        // RAW on rs1
        add(3'b101, f3(0,0,0), 3'b000, t3(5,0,6), Z, Z,    3'b100, 3'b000, f3(0,0,0), 0, 0);
        add(3'b001, f3(0,0,0), 3'b000, t3(0,0,6), Z, Z,    3'b000, 3'b001, f3(0,0,2), 1, 6);
        add(3'b001, f3(0,0,0), 3'b000, t3(0,0,6), Z, Z,    3'b001, 3'b000, f3(0,0,0), 0, 0);
        // rd=0 load never blocks
        add(3'b001, f3(0,0,2), 3'b001, Z, Z, Z,            3'b001, 3'b001, f3(0,0,0), 0, 0);
        add(3'b010, f3(0,0,0), 3'b000, Z, Z, Z,            3'b010, 3'b100, f3(0,0,0), 0, 0);
        add(3'b000, f3(0,0,0), 3'b000, Z, Z, Z,            3'b000, 3'b001, f3(0,0,1), 0, 0);
        // invalid FU id, RAW via rs2, WAW via rd
        add(3'b011, f3(0,2,3), 3'b010, Z, Z, t3(0,10,0),   3'b010, 3'b000, f3(0,0,0), 1, 0);
        add(3'b111, f3(1,0,3), 3'b000, Z, t3(0,10,0), t3(10,0,0), 3'b000, 3'b100, f3(1,0,0), 0, 0);
        add(3'b111, f3(1,0,3), 3'b000, Z, t3(0,10,0), t3(10,0,0), 3'b000, 3'b000, f3(0,0,0), 0, 0);
        add(3'b111, f3(1,0,3), 3'b000, Z, t3(0,10,0), t3(10,0,0), 3'b000, 3'b000, f3(0,0,0), 1, 10);
        add(3'b111, f3(1,0,3), 3'b000, Z, t3(0,10,0), t3(10,0,0), 3'b110, 3'b000, f3(0,0,0), 0, 0);
        add(3'b000, f3(0,0,0), 3'b000, Z, Z, Z,            3'b000, 3'b011, f3(0,2,1), 0, 0);

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int n = 0; n < tv.size(); n++) begin
            drive(tv[n].v, tv[n].fu, tv[n].ld, tv[n].rs1, tv[n].rs2, tv[n].rd);
            @(negedge clk);
            chk($sformatf("r%0d req_ready", n),   32'(req_ready),   32'(tv[n].e_rdy));
            chk($sformatf("r%0d grant_valid", n), 32'(grant_valid), 32'(tv[n].e_gv));
            chk($sformatf("r%0d grant_slot", n),  32'(grant_slot),  32'(tv[n].e_gs));
            chk($sformatf("r%0d wb_valid", n),    32'(wb_valid),    32'(tv[n].e_wb));
            if (tv[n].e_wb || n == 0)
                chk($sformatf("r%0d wb_rd", n),   32'(wb_rd),       32'(tv[n].e_wbrd));
            next_cycle();
        end

        // reset in the middle of a load to r9
        drive(3'b001, f3(0,0,2), 3'b001, Z, Z, t3(0,0,9));
        @(negedge clk);
        chk("rstmid load accepted", 32'(req_ready), 32'b001);
        next_cycle();
        idle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid lsu grant", 32'(grant_valid), 32'b100);
        next_cycle();
        rst = 1'b0;
        drive(3'b001, f3(0,0,0), 3'b000, t3(0,0,9), Z, Z);
        @(negedge clk);
        chk("rstmid add ready",   32'(req_ready),   32'b001);
        chk("rstmid grant_valid", 32'(grant_valid), 32'b000);
        chk("rstmid grant_slot",  32'(grant_slot),  32'b000);
        chk("rstmid wb_valid",    32'(wb_valid),    32'b0);
        chk("rstmid wb_rd",       32'(wb_rd),       32'b0);
        next_cycle();
        idle();
        @(negedge clk);
        chk("rstmid add granted", 32'(grant_valid), 32'b001);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rstmid no wb c%0d", c), 32'(wb_valid), 32'b0);
        end
        next_cycle();

`ifdef TTA_SCHED_PERF_EN
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        drive(3'b001, f3(0,0,3), 3'b000, Z, Z, Z);
        repeat (10) next_cycle();
        idle();
        @(negedge clk);
        chk("perf stall 10",  perf_stall_cnt,    32'd10);
        chk("perf deny 0",    perf_bus_deny_cnt, 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("perf stall rst", perf_stall_cnt,    32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
